alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 123 ++++++++++++
 tb/tb_alu_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler for one shared ALU.
// Define ALU_SCHED_ERR_EN to flag op 01 as an error without using the ALU.
module alu_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_con_sig,
  input  logic [WIDTH-1:0] alu_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic [1:0]       grant;
  logic             gid;
  logic             acc;
  logic             err_op;
  logic [1:0]       g_op;
  logic [WIDTH-1:0] g_a;
  logic [WIDTH-1:0] g_b;

  // Grant: lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && rst_n) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Steer the winner's request fields.
  always_comb begin
    gid  = grant[1];
    g_op = gid ? req_op1 : req_op0;
    g_a  = gid ? req_a1  : req_a0;
    g_b  = gid ? req_b1  : req_b0;
  end

  assign req_ready = grant;
  assign acc       = |grant;
  assign busy      = (state != IDLE);

`ifdef ALU_SCHED_ERR_EN
  assign err_op = (g_op == 2'b01);
`else
  assign err_op = 1'b0;
`endif

  // Transaction FSM; ALU operand regs only load on a real issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b1;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_con_sig <= 2'b00;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            rr_ptr  <= gid;
            resp_id <= gid;
            if (err_op) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              state      <= RESP;
            end else begin
              alu_in1     <= g_a;
              alu_in2     <= g_b;
              alu_con_sig <= g_op;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          resp_data  <= alu_out;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed scoreboard bench for alu_sched.
// Bench supplies the combinational ALU (op 01 behaves as xor).
module tb_alu_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic [1:0]   alu_con_sig;
  logic         resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [W-1:0] resp_data;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(
    input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a ^ b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_con_sig, alu_in1, alu_in2);

  alu_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_con_sig(alu_con_sig), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id   = (who == 1);
    e.err  = 1'b0;
    e.data = ref_alu(op, a, b);
`ifdef ALU_SCHED_ERR_EN
    if (op == 2'b01) begin
      e.err  = 1'b1;
      e.data = '0;
    end
`endif
    sb.push_back(e);
    if (who == 1) begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
    end
  endtask

  task automatic accept(input logic [1:0] who, input string tag);
    int n = 0;
    while (req_ready !== who && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_grant"}, req_ready, who);
    @(negedge clk);
    req_valid = req_valid & ~who;
    #1;
  endtask

  task automatic wait_resp(input string tag);
    exp_t e;
    int n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_rvalid"}, resp_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, resp_id, e.id);
      chk({tag, "_data"}, resp_data, e.data);
      chk({tag, "_err"}, resp_err, e.err);
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_done"}, resp_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; resp_ready = 1'b0; req_valid = 2'b11;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_con", alu_con_sig, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Single add, exact latency.
    @(negedge clk);
    drive(0, 2'b00, 16'h0003, 16'h0004);
    #1;
    accept(2'b01, "t1");
    chk("t1_busy", busy, 1);
    chk("t1_ready_issue", req_ready, 0);
    chk("t1_con", alu_con_sig, 2'b00);
    chk("t1_in1", alu_in1, 16'h0003);
    chk("t1_in2", alu_in2, 16'h0004);
    chk("t1_rvalid_n1", resp_valid, 0);
    @(negedge clk); #1;
    chk("t1_rvalid_n2", resp_valid, 1);
    wait_resp("t1");
    @(negedge clk); #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_hold_in1", alu_in1, 16'h0003);
    chk("t1_hold_con", alu_con_sig, 2'b00);

    // Tie right after reset: requester 0 first.
    do_reset();
    drive(0, 2'b10, 16'hF0F0, 16'h0FF0);
    drive(1, 2'b11, 16'h1200, 16'h0034);
    #1;
    accept(2'b01, "t2a");
    wait_resp("t2a");
    accept(2'b10, "t2b");
    wait_resp("t2b");

    // Tie after granting 1 goes to 0; wrap add; long stall.
    @(negedge clk);
    drive(0, 2'b00, 16'hFFFF, 16'h0002);
    drive(1, 2'b11, 16'h00A5, 16'h5A00);
    #1;
    accept(2'b01, "t3");
    @(negedge clk); #1;
    chk("t3_rvalid", resp_valid, 1);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_ready", req_ready, 2'b00);
      chk("t3_stall_valid", resp_valid, 1);
      chk("t3_stall_data", resp_data, e.data);
      chk("t3_stall_id", resp_id, e.id);
      chk("t3_stall_err", resp_err, e.err);
      @(negedge clk); #1;
    end
    wait_resp("t3");
    chk("t4_next_grant", req_ready, 2'b10);
    accept(2'b10, "t4");
    wait_resp("t4");

    // Reserved op 01.
    @(negedge clk);
    drive(0, 2'b01, 16'h1234, 16'h00FF);
    #1;
    accept(2'b01, "t5");
`ifdef ALU_SCHED_ERR_EN
    chk("t5_rvalid_n1", resp_valid, 1);
    chk("t5_in1_hold", alu_in1, 16'h00A5);
`else
    chk("t5_rvalid_n1", resp_valid, 0);
    chk("t5_in1", alu_in1, 16'h1234);
    chk("t5_con", alu_con_sig, 2'b01);
`endif
    wait_resp("t5");

    // Reset while a response is pending.
    @(negedge clk);
    drive(1, 2'b10, 16'hFF00, 16'h0F0F);
    #1;
    accept(2'b10, "t6");
    @(negedge clk); #1;
    chk("t6_rvalid", resp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rvalid", resp_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", req_ready, 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t6_no_resp", resp_valid, 0);
    end
    resp_ready = 1'b0;
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
